// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing each instruction over 3-5 cycles,
// with a memory ready handshake, a sticky illegal-instruction trap and a retired counter.
module multi_cycle_control #(
  parameter int unsigned ALU_OP_W      = 4,
  parameter int unsigned CNT_W         = 32,
  parameter bit          USE_MEM_READY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                imm_zext,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_op,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExec     = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StJump     = 4'd9,
    StImmExec  = 4'd10,
    StImmWb    = 4'd11,
    StTrap     = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;

  localparam logic [ALU_OP_W-1:0] AluAnd = ALU_OP_W'(4'b0000);
  localparam logic [ALU_OP_W-1:0] AluOr  = ALU_OP_W'(4'b0001);
  localparam logic [ALU_OP_W-1:0] AluAdd = ALU_OP_W'(4'b0010);
  localparam logic [ALU_OP_W-1:0] AluSub = ALU_OP_W'(4'b0110);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             ready;

  assign ready = USE_MEM_READY ? mem_ready : 1'b1;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      StFetch:    if (ready) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpRtype: begin
            if (funct == FnAdd || funct == FnSub || funct == FnAnd || funct == FnOr) begin
              state_d = StExec;
            end else begin
              state_d = StTrap;
            end
          end
          OpAddi, OpOri: state_d = StImmExec;
          OpBeq:         state_d = StBranch;
          OpJ:           state_d = StJump;
          OpLw, OpSw:    state_d = StMemAddr;
          default:       state_d = StTrap;
        endcase
      end
      StMemAddr:  state_d = (opcode == OpSw) ? StMemWrite : StMemRead;
      StMemRead:  if (ready) state_d = StMemWb;
      StMemWrite: if (ready) begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExec:     state_d = StRWb;
      StImmExec:  state_d = StImmWb;
      StMemWb, StRWb, StBranch, StJump, StImmWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StTrap:     state_d = StTrap;
      // Encodings 13-15 can only arise from corruption; park in the trap.
      default:    state_d = StTrap;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_op        = '0;
    illegal_op    = 1'b0;
    // Outputs are held low for the whole time reset is asserted.
    if (rst_n) begin
      case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = AluAdd;
          ir_write  = ready;
          pc_write  = ready;
        end
        StDecode: begin
          alu_src_b = 2'b11;
          alu_op    = AluAdd;
        end
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = AluAdd;
        end
        StMemRead: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        StMemWrite: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        StExec: begin
          alu_src_a = 1'b1;
          case (funct)
            FnSub:   alu_op = AluSub;
            FnAnd:   alu_op = AluAnd;
            FnOr:    alu_op = AluOr;
            default: alu_op = AluAdd;
          endcase
        end
        StRWb: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = AluSub;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
        end
        StJump: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        StImmExec: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OpOri) begin
            alu_op   = AluOr;
            imm_zext = 1'b1;
          end else begin
            alu_op = AluAdd;
          end
        end
        StImmWb:   reg_write  = 1'b1;
        StTrap:    illegal_op = 1'b1;
        default:   illegal_op = 1'b0;
      endcase
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: stimulus pushes the expected per-cycle control word,
// a negedge monitor pops and compares it against the DUT outputs.
module tb_multi_cycle_control;

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpAdi = 6'b001000;
  localparam logic [5:0] OpOri = 6'b001101;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpJ   = 6'b000010;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;
  localparam logic [5:0] OpBad = 6'b111111;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw;
    logic       pcwc;
    logic [1:0] pcs;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic       zx;
    logic [3:0] aop;
    logic       ill;
    logic [3:0] ret;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, imm_zext, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_op, state, retired;

  vec_t  exp_q[$];
  string tag_q[$];
  vec_t  act;
  int    n_chk = 0;
  int    n_fail = 0;
  logic [3:0] exp_ret = '0;

  always #5 clk = ~clk;

  multi_cycle_control #(
    .ALU_OP_W(4),
    .CNT_W(4),
    .USE_MEM_READY(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .illegal_op(illegal_op),
    .state(state), .retired(retired)
  );

  always_comb begin
    act      = '0;
    act.st   = state;      act.pcw  = pc_write;   act.pcwc = pc_write_cond;
    act.pcs  = pc_source;  act.iord = iord;       act.mrd  = mem_read;
    act.mwr  = mem_write;  act.irw  = ir_write;   act.rdst = reg_dst;
    act.m2r  = mem_to_reg; act.rw   = reg_write;  act.sa   = alu_src_a;
    act.sb   = alu_src_b;  act.zx   = imm_zext;   act.aop  = alu_op;
    act.ill  = illegal_op; act.ret  = retired;
  end

  // Control word each state must present, straight from the state table.
  function automatic vec_t exp_out(input logic [3:0] st, input logic rdy, input logic [3:0] aop,
                                   input logic zx, input logic [3:0] ret);
    vec_t v;
    v = '0;
    v.st  = st;
    v.ret = ret;
    case (st)
      4'd0:  begin v.mrd = 1; v.sb = 2'b01; v.aop = 4'b0010; v.irw = rdy; v.pcw = rdy; end
      4'd1:  begin v.sb = 2'b11; v.aop = 4'b0010; end
      4'd2:  begin v.sa = 1; v.sb = 2'b10; v.aop = 4'b0010; end
      4'd3:  begin v.mrd = 1; v.iord = 1; end
      4'd4:  begin v.rw = 1; v.m2r = 1; end
      4'd5:  begin v.mwr = 1; v.iord = 1; end
      4'd6:  begin v.sa = 1; v.aop = aop; end
      4'd7:  begin v.rw = 1; v.rdst = 1; end
      4'd8:  begin v.sa = 1; v.aop = 4'b0110; v.pcwc = 1; v.pcs = 2'b01; end
      4'd9:  begin v.pcw = 1; v.pcs = 2'b10; end
      4'd10: begin v.sa = 1; v.sb = 2'b10; v.aop = aop; v.zx = zx; end
      4'd11: v.rw = 1;
      4'd12: v.ill = 1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                     input logic [3:0] st, input logic [3:0] aop, input logic zx, input string tag);
    @(posedge clk);
    #1;
    opcode    = op;
    funct     = fn;
    mem_ready = rdy;
    exp_q.push_back(exp_out(st, rdy, aop, zx, exp_ret));
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      mem_ready = 1'b0;
      exp_q.push_back('0);
      tag_q.push_back("in_reset");
    end
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(exp_out(4'd0, 1'b0, 4'd0, 1'b0, 4'd0));
    tag_q.push_back("fetch_hold");
  endtask

  task automatic run_r(input logic [5:0] fn, input logic [3:0] aop, input string tag);
    cyc(OpR, fn, 1, 4'd0, 0, 0, {tag, "_fetch"});
    cyc(OpR, fn, 1, 4'd1, 0, 0, {tag, "_decode"});
    cyc(OpR, fn, 1, 4'd6, aop, 0, {tag, "_exec"});
    cyc(OpR, fn, 1, 4'd7, 0, 0, {tag, "_wb"});
    exp_ret++;
  endtask

  task automatic run_imm(input logic [5:0] op, input logic [3:0] aop, input logic zx,
                         input string tag);
    cyc(op, 0, 1, 4'd0, 0, 0, {tag, "_fetch"});
    cyc(op, 0, 1, 4'd1, 0, 0, {tag, "_decode"});
    cyc(op, 0, 1, 4'd10, aop, zx, {tag, "_exec"});
    cyc(op, 0, 1, 4'd11, 0, 0, {tag, "_wb"});
    exp_ret++;
  endtask

  task automatic run_short(input logic [5:0] op, input logic [3:0] st, input string tag);
    cyc(op, 0, 1, 4'd0, 0, 0, {tag, "_fetch"});
    cyc(op, 0, 1, 4'd1, 0, 0, {tag, "_decode"});
    cyc(op, 0, 1, st, 0, 0, {tag, "_exec"});
    exp_ret++;
  endtask

  always @(negedge clk) begin
    vec_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", t, act, e);
      end
    end
  end

  initial begin
    do_reset();

    run_r(6'b100000, 4'b0010, "add");

    // lw with two wait states in MEM_READ: 7 cycles total
    cyc(OpLw, 0, 1, 4'd0, 0, 0, "lw_fetch");
    cyc(OpLw, 0, 1, 4'd1, 0, 0, "lw_decode");
    cyc(OpLw, 0, 1, 4'd2, 0, 0, "lw_addr");
    cyc(OpLw, 0, 0, 4'd3, 0, 0, "lw_wait0");
    cyc(OpLw, 0, 0, 4'd3, 0, 0, "lw_wait1");
    cyc(OpLw, 0, 1, 4'd3, 0, 0, "lw_read");
    cyc(OpLw, 0, 1, 4'd4, 0, 0, "lw_wb");
    exp_ret++;

    run_r(6'b100010, 4'b0110, "sub");
    run_r(6'b100100, 4'b0000, "and");
    run_r(6'b100101, 4'b0001, "or");

    // sw with one fetch wait and one write wait
    cyc(OpSw, 0, 0, 4'd0, 0, 0, "sw_fetch_wait");
    cyc(OpSw, 0, 1, 4'd0, 0, 0, "sw_fetch");
    cyc(OpSw, 0, 1, 4'd1, 0, 0, "sw_decode");
    cyc(OpSw, 0, 1, 4'd2, 0, 0, "sw_addr");
    cyc(OpSw, 0, 0, 4'd5, 0, 0, "sw_wait");
    cyc(OpSw, 0, 1, 4'd5, 0, 0, "sw_write");
    exp_ret++;

    run_imm(OpAdi, 4'b0010, 1'b0, "addi");
    run_imm(OpOri, 4'b0001, 1'b1, "ori");
    run_short(OpBeq, 4'd8, "beq");
    run_short(OpJ, 4'd9, "j");

    // Illegal opcode: trap is sticky and retired does not move
    cyc(OpBad, 0, 1, 4'd0, 0, 0, "bad_fetch");
    cyc(OpBad, 0, 1, 4'd1, 0, 0, "bad_decode");
    for (int i = 0; i < 10; i++) cyc(OpJ, 0, 1, 4'd12, 0, 0, "trap_hold");
    do_reset();

    // Unsupported R-type funct
    cyc(OpR, 6'b000000, 1, 4'd0, 0, 0, "badfn_fetch");
    cyc(OpR, 6'b000000, 1, 4'd1, 0, 0, "badfn_decode");
    for (int i = 0; i < 3; i++) cyc(OpR, 0, 1, 4'd12, 0, 0, "badfn_trap");
    do_reset();

    // 17 jumps wrap a 4-bit counter to 1
    for (int i = 0; i < 17; i++) run_short(OpJ, 4'd9, "jwrap");
    cyc(OpJ, 0, 0, 4'd0, 0, 0, "jwrap_final");

    // Reset dropped mid MEM_WRITE: outputs must clear before the next clock edge
    cyc(OpSw, 0, 1, 4'd0, 0, 0, "swr_fetch");
    cyc(OpSw, 0, 1, 4'd1, 0, 0, "swr_decode");
    cyc(OpSw, 0, 1, 4'd2, 0, 0, "swr_addr");
    cyc(OpSw, 0, 0, 4'd5, 0, 0, "swr_wait");
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("async_reset");
    #1;
    rst_n = 1'b0;
    do_reset();
    run_r(6'b100000, 4'b0010, "post_reset_add");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
